// File: rtl/slavefifo2b_pkg.sv
// Shared encodings for the FX3 slave-FIFO 2-bit bus multiplexer.
// Holds the requested-mode encoding and the mux FSM state encoding.
package slavefifo2b_pkg;

    typedef enum logic [1:0] {
        MODE_NONE    = 2'd0,
        MODE_STREAM  = 2'd1,
        MODE_PARTIAL = 2'd2,
        MODE_ZLP     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/slavefifo2b_bus_mux.sv
// Multiplexes three FX3 write generators onto one slave-FIFO bus with a drain gap between modes.
// Optional write-strobe counter enabled by defining SLAVEFIFO2B_WR_COUNT_EN.
module slavefifo2b_bus_mux
    import slavefifo2b_pkg::*;
#(
    parameter int DRAIN_CYCLES = 8
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic [1:0]  mode_sel,
    input  logic        flaga,
    input  logic        flagb,
    output logic        flaga_d,
    output logic        flagb_d,
    output logic        stream_mode_selected,
    output logic        partial_mode_selected,
    output logic        zlp_mode_selected,
    input  logic        slwr_stream_,
    input  logic        slwr_partial_,
    input  logic        slwr_zlp_,
    input  logic        pktend_stream_,
    input  logic        pktend_partial_,
    input  logic        pktend_zlp_,
    input  logic [31:0] data_stream,
    input  logic [31:0] data_partial,
    input  logic [31:0] data_zlp,
    output logic        slwr_,
    output logic        pktend_,
    output logic [31:0] fdata,
    output logic [1:0]  faddr,
    output logic        slcs_,
    output logic        sloe_,
    output logic        slrd_,
    output logic [31:0] wr_count
);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES);

    state_e            state_q, state_d;
    mode_e             mode_q;
    mode_e             active_q, active_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flaga_q, flagb_q;
    logic              slwr_q, slwr_d;
    logic              pktend_q, pktend_d;
    logic [31:0]       fdata_q, fdata_d;
    logic              run;
    logic              gen_slwr, gen_pktend;
    logic [31:0]       gen_data;

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_NONE;
            active_q <= MODE_NONE;
            cnt_q    <= '0;
            flaga_q  <= 1'b0;
            flagb_q  <= 1'b0;
            slwr_q   <= 1'b1;
            pktend_q <= 1'b1;
            fdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_e'(mode_sel);
            active_q <= active_d;
            cnt_q    <= cnt_d;
            flaga_q  <= flaga;
            flagb_q  <= flagb;
            slwr_q   <= slwr_d;
            pktend_q <= pktend_d;
            fdata_q  <= fdata_d;
        end
    end

    // DRAIN exits once the counter reaches DRAIN_CYCLES, i.e. it holds the bus quiet for DRAIN_CYCLES+1 cycles.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mode_q != MODE_NONE) begin
                    active_d = mode_q;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mode_q != active_q) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gen_slwr   = 1'b1;
        gen_pktend = 1'b1;
        gen_data   = fdata_q;
        case (active_q)
            MODE_STREAM:  begin gen_slwr = slwr_stream_;  gen_pktend = pktend_stream_;  gen_data = data_stream;  end
            MODE_PARTIAL: begin gen_slwr = slwr_partial_; gen_pktend = pktend_partial_; gen_data = data_partial; end
            MODE_ZLP:     begin gen_slwr = slwr_zlp_;     gen_pktend = pktend_zlp_;     gen_data = data_zlp;     end
            default:      ;
        endcase
    end

    // The strobe sampled on the RUN->DRAIN edge still reaches the bus because run is taken from state_q.
    assign run      = (state_q == ST_RUN);
    assign slwr_d   = run ? gen_slwr : 1'b1;
    assign pktend_d = (run && flaga_q) ? gen_pktend : 1'b1;
    assign fdata_d  = run ? gen_data : fdata_q;

    assign stream_mode_selected  = run && (active_q == MODE_STREAM);
    assign partial_mode_selected = run && (active_q == MODE_PARTIAL);
    assign zlp_mode_selected     = run && (active_q == MODE_ZLP);

    assign flaga_d = flaga_q;
    assign flagb_d = flagb_q;
    assign slwr_   = slwr_q;
    assign pktend_ = pktend_q;
    assign fdata   = fdata_q;
    assign faddr   = 2'b00;
    assign slcs_   = 1'b0;
    assign sloe_   = 1'b1;
    assign slrd_   = 1'b1;

`ifdef SLAVEFIFO2B_WR_COUNT_EN
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            wr_cnt_q <= '0;
        end else if (!slwr_q) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign wr_count = wr_cnt_q;
`else
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_slavefifo2b_bus_mux.sv
// Self-checking bench for slavefifo2b_bus_mux: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the mode/drain rules.
module tb_slavefifo2b_bus_mux;

    localparam int DRAIN_CYCLES = 8;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2;

    logic        clk_100 = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode_sel = 2'd0;
    logic        flaga = 1'b0, flagb = 1'b0;
    logic        flaga_d, flagb_d;
    logic        stream_mode_selected, partial_mode_selected, zlp_mode_selected;
    logic        slwr_stream_ = 1'b1, slwr_partial_ = 1'b1, slwr_zlp_ = 1'b1;
    logic        pktend_stream_ = 1'b1, pktend_partial_ = 1'b1, pktend_zlp_ = 1'b1;
    logic [31:0] data_stream = '0, data_partial = '0, data_zlp = '0;
    logic        slwr_, pktend_;
    logic [31:0] fdata;
    logic [1:0]  faddr;
    logic        slcs_, sloe_, slrd_;
    logic [31:0] wr_count;

    always #5 clk_100 = ~clk_100;

    slavefifo2b_bus_mux #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk_100(clk_100), .reset(reset), .mode_sel(mode_sel),
        .flaga(flaga), .flagb(flagb), .flaga_d(flaga_d), .flagb_d(flagb_d),
        .stream_mode_selected(stream_mode_selected),
        .partial_mode_selected(partial_mode_selected),
        .zlp_mode_selected(zlp_mode_selected),
        .slwr_stream_(slwr_stream_), .slwr_partial_(slwr_partial_), .slwr_zlp_(slwr_zlp_),
        .pktend_stream_(pktend_stream_), .pktend_partial_(pktend_partial_), .pktend_zlp_(pktend_zlp_),
        .data_stream(data_stream), .data_partial(data_partial), .data_zlp(data_zlp),
        .slwr_(slwr_), .pktend_(pktend_), .fdata(fdata), .faddr(faddr),
        .slcs_(slcs_), .sloe_(sloe_), .slrd_(slrd_), .wr_count(wr_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase + remaining quiet cycles, bus outputs one cycle behind inputs.
    int          m_mode_q, m_phase, m_active, m_left;
    bit          m_fa, m_fb, m_slwr, m_pkt;
    logic [31:0] m_fdata, m_wr;

    task automatic model_reset();
        m_mode_q = 0; m_phase = P_IDLE; m_active = 0; m_left = 0;
        m_fa = 0; m_fb = 0; m_slwr = 1; m_pkt = 1; m_fdata = '0; m_wr = '0;
    endtask

    task automatic model_tick();
        bit          gs, gp, n_slwr, n_pkt;
        logic [31:0] gd, n_fd;
        gs = (m_active == 1) ? slwr_stream_   : (m_active == 2) ? slwr_partial_   : slwr_zlp_;
        gp = (m_active == 1) ? pktend_stream_ : (m_active == 2) ? pktend_partial_ : pktend_zlp_;
        gd = (m_active == 1) ? data_stream    : (m_active == 2) ? data_partial    : data_zlp;
        n_slwr = 1; n_pkt = 1; n_fd = m_fdata;
        if (m_phase == P_RUN) begin
            n_slwr = gs;
            n_pkt  = m_fa ? gp : 1'b1;
            n_fd   = gd;
        end
        if (!m_slwr) m_wr = m_wr + 1;
        if (m_phase == P_IDLE) begin
            if (m_mode_q != 0) begin m_phase = P_RUN; m_active = m_mode_q; end
        end else if (m_phase == P_RUN) begin
            if (m_mode_q != m_active) begin m_phase = P_DRAIN; m_left = DRAIN_CYCLES + 1; end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = P_IDLE;
        end
        m_slwr = n_slwr; m_pkt = n_pkt; m_fdata = n_fd;
        m_mode_q = int'(mode_sel); m_fa = flaga; m_fb = flagb;
    endtask

    function automatic bit exp_sel(int mode);
        return (m_phase == P_RUN) && (m_active == mode);
    endfunction

    function automatic logic [31:0] exp_wr();
`ifdef SLAVEFIFO2B_WR_COUNT_EN
        return m_wr;
`else
        return 32'd0;
`endif
    endfunction

    task automatic cycle();
        if (reset) model_reset(); else model_tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic idle_inputs();
        slwr_stream_ = 1; slwr_partial_ = 1; slwr_zlp_ = 1;
        pktend_stream_ = 1; pktend_partial_ = 1; pktend_zlp_ = 1;
        data_stream = '0; data_partial = '0; data_zlp = '0;
    endtask

    task automatic do_reset();
        reset = 1; model_reset(); idle_inputs(); mode_sel = 0;
        repeat (2) cycle();
        reset = 0;
    endtask

    // Returns cycles waited until the given mode is selected, or -1 after 20 cycles.
    task automatic wait_mode(input int mode, output int n);
        n = -1;
        for (int i = 1; i <= 20 && n < 0; i++) begin
            cycle();
            if ({stream_mode_selected, partial_mode_selected, zlp_mode_selected} == 3'(1 << (3 - mode))) n = i;
        end
    endtask

    task automatic test_reset();
        flaga = 1; flagb = 1; reset = 1; model_reset();
        repeat (3) cycle();
        n_tests++; if (slwr_ !== 1'b1) begin n_fail++; $display("FAIL reset_slwr got %b want 1", slwr_); end
        n_tests++; if (pktend_ !== 1'b1) begin n_fail++; $display("FAIL reset_pktend got %b want 1", pktend_); end
        n_tests++; if (fdata !== 32'd0) begin n_fail++; $display("FAIL reset_fdata got %h want 0", fdata); end
        n_tests++; if ({stream_mode_selected, partial_mode_selected, zlp_mode_selected} !== 3'b000) begin
            n_fail++; $display("FAIL reset_sel got %b want 000", {stream_mode_selected, partial_mode_selected, zlp_mode_selected}); end
        n_tests++; if ({flaga_d, flagb_d} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {flaga_d, flagb_d}); end
        n_tests++; if (wr_count !== 32'd0) begin n_fail++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
        n_tests++; if ({faddr, slcs_, sloe_, slrd_} !== 5'b00011) begin
            n_fail++; $display("FAIL ctrl_pins got %b want 00011", {faddr, slcs_, sloe_, slrd_}); end
    endtask

    task automatic test_partial_basic();
        do_reset();
        flaga = 1; flagb = 1; mode_sel = 2;
        cycle();
        n_tests++; if (partial_mode_selected !== 1'b0) begin n_fail++; $display("FAIL partial_early got %b want 0", partial_mode_selected); end
        cycle();
        n_tests++; if ({stream_mode_selected, partial_mode_selected, zlp_mode_selected} !== 3'b010) begin
            n_fail++; $display("FAIL partial_sel got %b want 010", {stream_mode_selected, partial_mode_selected, zlp_mode_selected}); end
        slwr_partial_ = 0; data_partial = 32'h5;
        cycle();
        n_tests++; if (slwr_ !== 1'b0) begin n_fail++; $display("FAIL partial_slwr got %b want 0", slwr_); end
        n_tests++; if (fdata !== 32'h5) begin n_fail++; $display("FAIL partial_fdata got %h want 5", fdata); end
        n_tests++; if (flaga_d !== 1'b1) begin n_fail++; $display("FAIL flaga_d got %b want 1", flaga_d); end
        slwr_partial_ = 1;
    endtask

    task automatic test_mode_switch();
        int n, k, hi_cnt, rise;
        do_reset();
        flaga = 1; mode_sel = 1;
        wait_mode(1, n);
        n_tests++; if (n < 0) begin n_fail++; $display("FAIL switch_enter_stream got timeout want select"); end
        slwr_stream_ = 0; data_stream = 32'hA5A5_0001;
        repeat (2) cycle();
        mode_sel = 3;
        k = 0;
        do begin cycle(); k++; end while (stream_mode_selected && k < 6);
        n_tests++; if (k > 2) begin n_fail++; $display("FAIL switch_drop got %0d cycles want <=2", k); end
        n_tests++; if ({slwr_, fdata} !== {1'b0, 32'hA5A5_0001}) begin
            n_fail++; $display("FAIL switch_last_write got %b/%h want 0/a5a50001", slwr_, fdata); end
        hi_cnt = 0; rise = -1;
        for (int i = 1; i <= 20 && rise < 0; i++) begin
            cycle();
            if (i <= 8 && slwr_ === 1'b1) hi_cnt++;
            if (zlp_mode_selected) rise = i;
        end
        n_tests++; if (hi_cnt != 8) begin n_fail++; $display("FAIL switch_quiet got %0d high cycles want 8", hi_cnt); end
        n_tests++; if (rise != 10) begin n_fail++; $display("FAIL switch_zlp_rise got %0d want 10", rise); end
        n_tests++; if ({stream_mode_selected, partial_mode_selected} !== 2'b00) begin
            n_fail++; $display("FAIL switch_onehot got %b want 00", {stream_mode_selected, partial_mode_selected}); end
        slwr_stream_ = 1;
    endtask

    task automatic test_pktend_full();
        int n, hi;
        do_reset();
        flaga = 1; mode_sel = 2;
        wait_mode(2, n);
        n_tests++; if (n < 0) begin n_fail++; $display("FAIL full_enter_partial got timeout want select"); end
        pktend_partial_ = 0;
        cycle();
        n_tests++; if (pktend_ !== 1'b0) begin n_fail++; $display("FAIL pktend_pass got %b want 0", pktend_); end
        pktend_partial_ = 1; flaga = 0;
        repeat (2) cycle();
        n_tests++; if (flaga_d !== 1'b0) begin n_fail++; $display("FAIL full_flaga_d got %b want 0", flaga_d); end
        pktend_partial_ = 0; hi = 0;
        repeat (5) begin cycle(); if (pktend_ === 1'b1) hi++; end
        n_tests++; if (hi != 5) begin n_fail++; $display("FAIL pktend_forced got %0d high cycles want 5", hi); end
        pktend_partial_ = 1; flaga = 1;
    endtask

    task automatic test_reset_mid_burst();
        int n;
        do_reset();
        flaga = 1; mode_sel = 1;
        wait_mode(1, n);
        n_tests++; if (n < 0) begin n_fail++; $display("FAIL burst_enter_stream got timeout want select"); end
        slwr_stream_ = 0;
        for (int i = 0; i < 40; i++) begin data_stream = $urandom | 32'h1; cycle(); end
        #2; reset = 1; model_reset();
        #1;
        n_tests++; if ({slwr_, pktend_} !== 2'b11) begin n_fail++; $display("FAIL async_strobes got %b want 11", {slwr_, pktend_}); end
        n_tests++; if (fdata !== 32'd0) begin n_fail++; $display("FAIL async_fdata got %h want 0", fdata); end
        n_tests++; if ({stream_mode_selected, partial_mode_selected, zlp_mode_selected} !== 3'b000) begin
            n_fail++; $display("FAIL async_sel got %b want 000", {stream_mode_selected, partial_mode_selected, zlp_mode_selected}); end
        idle_inputs(); mode_sel = 0;
        repeat (2) cycle();
        reset = 0;
    endtask

    task automatic test_wr_count();
        int n;
        logic [31:0] want;
        do_reset();
        flaga = 1; mode_sel = 1;
        wait_mode(1, n);
        n_tests++; if (n < 0) begin n_fail++; $display("FAIL count_enter_stream got timeout want select"); end
        slwr_stream_ = 0;
        repeat (1024) begin data_stream = $urandom; cycle(); end
        slwr_stream_ = 1;
        repeat (2) cycle();
`ifdef SLAVEFIFO2B_WR_COUNT_EN
        want = 32'd1024;
`else
        want = 32'd0;
`endif
        n_tests++; if (wr_count !== want) begin n_fail++; $display("FAIL wr_count got %0d want %0d", wr_count, want); end
    endtask

    task automatic test_drain_toggle();
        int n, k, rises, first;
        bit prev;
        do_reset();
        flaga = 1; mode_sel = 1;
        wait_mode(1, n);
        n_tests++; if (n < 0) begin n_fail++; $display("FAIL toggle_enter_stream got timeout want select"); end
        mode_sel = 0;
        k = 0;
        do begin cycle(); k++; end while (stream_mode_selected && k < 6);
        n_tests++; if (stream_mode_selected !== 1'b0) begin n_fail++; $display("FAIL toggle_drop got %b want 0", stream_mode_selected); end
        cycle(); mode_sel = 1;
        cycle(); cycle(); mode_sel = 0;
        cycle(); mode_sel = 1;
        rises = 0; first = -1; prev = 0;
        for (int i = 5; i <= 34; i++) begin
            cycle();
            if (stream_mode_selected && !prev) begin rises++; if (first < 0) first = i; end
            prev = stream_mode_selected;
        end
        n_tests++; if (rises != 1) begin n_fail++; $display("FAIL toggle_reentries got %0d want 1", rises); end
        n_tests++; if (first != 10) begin n_fail++; $display("FAIL toggle_reentry_cycle got %0d want 10", first); end
    endtask

    task automatic test_random();
        logic [70:0] got, exp;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) mode_sel = 2'($urandom);
            flaga = ($urandom_range(0, 7) != 0);
            flagb = 1'($urandom);
            slwr_stream_ = 1'($urandom); slwr_partial_ = 1'($urandom); slwr_zlp_ = 1'($urandom);
            pktend_stream_ = ($urandom_range(0, 3) != 0);
            pktend_partial_ = ($urandom_range(0, 3) != 0);
            pktend_zlp_ = ($urandom_range(0, 3) != 0);
            data_stream = $urandom; data_partial = $urandom; data_zlp = $urandom;
            cycle();
            got = {slwr_, pktend_, fdata, stream_mode_selected, partial_mode_selected, zlp_mode_selected,
                   flaga_d, flagb_d, wr_count};
            exp = {m_slwr, m_pkt, m_fdata, exp_sel(1), exp_sel(2), exp_sel(3), m_fa, m_fb, exp_wr()};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle_%0d got %h want %h", i, got, exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_partial_basic();
        test_mode_switch();
        test_pktend_full();
        test_reset_mid_burst();
        test_wr_count();
        test_drain_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
